// File: rtl/seg7_pkg.sv
// Shared segment encodings, scan index type and the BCD-to-segment helper
// used by the 4-digit common-anode 7-segment scan driver.
package seg7_pkg;

    // Patterns are {g,f,e,d,c,b,a}, active-low (0 lights a segment)
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ERR   = 7'b0000110;

    typedef enum logic [1:0] {
        IDX_ONE  = 2'd0,
        IDX_TEN  = 2'd1,
        IDX_HUN  = 2'd2,
        IDX_SIGN = 2'd3
    } idx_e;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_ERR;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder with minus and blank overrides;
// one instance serves all four scan slots on the muxed nibble.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    input  logic       minus,
    output logic [6:0] seg
);

    always_comb begin
        seg = bcd_to_seg(nibble);
        if (minus) begin
            seg = SEG_MINUS;
        end else if (blank) begin
            seg = SEG_BLANK;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Latches a hun/ten/one/neg digit set and time-multiplexes it onto a 4-digit
// common-anode display. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD_CYC   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bcd_valid,
    input  logic [3:0] hun,
    input  logic [3:0] ten,
    input  logic [3:0] one,
    input  logic       neg,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD_CYC);

    logic [3:0]    hun_q, hun_d;
    logic [3:0]    ten_q, ten_d;
    logic [3:0]    one_q, one_d;
    logic          neg_q, neg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    idx_e          idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    logic [3:0]    mux_nibble;
    logic          mux_blank;
    logic          mux_minus;
    logic          blank_hun;
    logic          blank_ten;
    logic [6:0]    dec_seg;

`ifdef LEADING_ZERO_BLANK_EN
    assign blank_hun = (hun_q == 4'd0);
    assign blank_ten = (hun_q == 4'd0) && (ten_q == 4'd0);
`else
    assign blank_hun = 1'b0;
    assign blank_ten = 1'b0;
`endif

    // Slot selection reads the hold registers, so a capture shows up one edge later
    always_comb begin
        mux_nibble = one_q;
        mux_blank  = 1'b0;
        mux_minus  = 1'b0;
        case (idx_q)
            IDX_ONE:  mux_nibble = one_q;
            IDX_TEN: begin
                mux_nibble = ten_q;
                mux_blank  = blank_ten;
            end
            IDX_HUN: begin
                mux_nibble = hun_q;
                mux_blank  = blank_hun;
            end
            IDX_SIGN: begin
                mux_nibble = 4'd0;
                mux_blank  = ~neg_q;
                mux_minus  = neg_q;
            end
            default:  mux_nibble = one_q;
        endcase
    end

    seg7_decode u_decode (
        .nibble (mux_nibble),
        .blank  (mux_blank),
        .minus  (mux_minus),
        .seg    (dec_seg)
    );

    always_comb begin
        hun_d = hun_q;
        ten_d = ten_q;
        one_d = one_q;
        neg_d = neg_q;
        cnt_d = cnt_q;
        idx_d = idx_q;
        an_d  = 4'b1111;
        seg_d = dec_seg;

        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_e'(idx_q + 2'd1);
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        // Capture may coincide with a wrap; both take effect on the same edge
        if (bcd_valid) begin
            hun_d = hun;
            ten_d = ten;
            one_d = one;
            neg_d = neg;
        end

        if (cnt_q >= CNT_GUARD) begin
            an_d = ~(4'b0001 << idx_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hun_q <= 4'd0;
            ten_q <= 4'd0;
            one_q <= 4'd0;
            neg_q <= 1'b0;
            cnt_q <= '0;
            idx_q <= IDX_ONE;
            an_q  <= 4'b1111;
            seg_q <= SEG_BLANK;
        end else begin
            hun_q <= hun_d;
            ten_q <= ten_d;
            one_q <= one_d;
            neg_q <= neg_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with a short refresh period; expected slot
// patterns come from a hand-written table, expected outputs go through a queue.
module tb_seg7_scan_driver;

    localparam int RD = 8;
    localparam int GC = 2;

    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] P1 = 7'b1111001;
    localparam logic [6:0] P2 = 7'b0100100;
    localparam logic [6:0] P3 = 7'b0110000;
    localparam logic [6:0] P4 = 7'b0011001;
    localparam logic [6:0] P5 = 7'b0010010;
    localparam logic [6:0] P6 = 7'b0000010;
    localparam logic [6:0] P7 = 7'b1111000;
    localparam logic [6:0] P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0010000;
    localparam logic [6:0] PM = 7'b0111111;
    localparam logic [6:0] PB = 7'b1111111;
    localparam logic [6:0] PE = 7'b0000110;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bcd_valid = 1'b0;
    logic [3:0] hun = 4'd0;
    logic [3:0] ten = 4'd0;
    logic [3:0] one = 4'd0;
    logic       neg = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    always #5 clk = ~clk;

    seg7_scan_driver #(.REFRESH_DIV(RD), .GUARD_CYC(GC)) dut (
        .clk       (clk),
        .rst       (rst),
        .bcd_valid (bcd_valid),
        .hun       (hun),
        .ten       (ten),
        .one       (one),
        .neg       (neg),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    // segs[i] is the pattern expected on slot i (0=one, 1=ten, 2=hun, 3=sign)
    typedef struct packed {
        logic [3:0]      hun;
        logic [3:0]      ten;
        logic [3:0]      one;
        logic            neg;
        logic [3:0][6:0] segs;
    } vec_t;

    vec_t       vecs[8];
    vec_t       rst_v;
    logic [11:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         m_cnt = 0;
    int         m_idx = 0;
    logic [3:0][6:0] m_segs;

    function automatic vec_t mk(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                                input logic n, input logic [6:0] s3, input logic [6:0] s2,
                                input logic [6:0] s1, input logic [6:0] s0);
        vec_t v;
        v.hun  = h;
        v.ten  = t;
        v.one  = o;
        v.neg  = n;
        v.segs = {s3, s2, s1, s0};
        return v;
    endfunction

    task automatic check_out();
        logic [11:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty t=%0t: got an=%b seg=%b, required a queued entry",
                     $time, an, seg);
        end else begin
            e = exp_q.pop_front();
            if ({an, seg, dp} !== e) begin
                errors++;
                $display("FAIL scan t=%0t slot=%0d: got an=%b seg=%b dp=%b, required an=%b seg=%b dp=%b",
                         $time, m_idx, an, seg, dp, e[11:8], e[7:1], e[0]);
            end
        end
    endtask

    task automatic step(input logic r, input logic v, input vec_t vv);
        logic [3:0] e_an;
        rst       = r;
        bcd_valid = v;
        if (v) begin
            hun = vv.hun;
            ten = vv.ten;
            one = vv.one;
            neg = vv.neg;
        end else begin
            hun = 4'($urandom_range(0, 15));
            ten = 4'($urandom_range(0, 15));
            one = 4'($urandom_range(0, 15));
            neg = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        if (r) begin
            exp_q.push_back({4'b1111, PB, 1'b1});
            m_cnt  = 0;
            m_idx  = 0;
            m_segs = rst_v.segs;
        end else begin
            e_an = (m_cnt < GC) ? 4'b1111 : ~(4'b0001 << m_idx);
            exp_q.push_back({e_an, m_segs[m_idx], 1'b1});
            if (m_cnt == RD - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_cnt++;
            end
            if (v) m_segs = vv.segs;
        end
        #1;
        check_out();
    endtask

    initial begin
`ifdef LEADING_ZERO_BLANK_EN
        rst_v   = mk(4'd0, 4'd0, 4'd0, 1'b0, PB, PB, PB, P0);
        vecs[3] = mk(4'd0, 4'd0, 4'd5, 1'b0, PB, PB, PB, P5);
        vecs[4] = mk(4'd0, 4'd0, 4'd0, 1'b1, PM, PB, PB, P0);
        vecs[5] = mk(4'd0, 4'd7, 4'd3, 1'b1, PM, PB, P7, P3);
`else
        rst_v   = mk(4'd0, 4'd0, 4'd0, 1'b0, PB, P0, P0, P0);
        vecs[3] = mk(4'd0, 4'd0, 4'd5, 1'b0, PB, P0, P0, P5);
        vecs[4] = mk(4'd0, 4'd0, 4'd0, 1'b1, PM, P0, P0, P0);
        vecs[5] = mk(4'd0, 4'd7, 4'd3, 1'b1, PM, P0, P7, P3);
`endif
        vecs[0] = mk(4'd1, 4'd2, 4'd5, 1'b0, PB, P1, P2, P5);
        vecs[1] = mk(4'd1, 4'd2, 4'd5, 1'b1, PM, P1, P2, P5);
        vecs[2] = mk(4'd1, 4'hA, 4'd5, 1'b1, PM, P1, PE, P5);
        vecs[6] = mk(4'd9, 4'd8, 4'd6, 1'b0, PB, P9, P8, P6);
        vecs[7] = mk(4'hF, 4'd4, 4'hE, 1'b1, PM, PE, P4, PE);
        m_segs  = rst_v.segs;

        // Reset held for three cycles
        repeat (3) step(1'b1, 1'b0, rst_v);

        // Table: capture each digit set at a random point, then watch a full scan
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 12)) step(1'b0, 1'b0, rst_v);
            step(1'b0, 1'b1, vecs[i]);
            repeat (4 * RD + 4) step(1'b0, 1'b0, rst_v);
        end

        // Capture on the exact wrap cycle
        for (int k = 0; k < RD && m_cnt != RD - 1; k++) step(1'b0, 1'b0, rst_v);
        step(1'b0, 1'b1, vecs[1]);
        repeat (4 * RD + 4) step(1'b0, 1'b0, rst_v);
        for (int k = 0; k < RD && m_cnt != RD - 1; k++) step(1'b0, 1'b0, rst_v);
        step(1'b0, 1'b1, vecs[7]);
        repeat (4 * RD + 4) step(1'b0, 1'b0, rst_v);

        // Reset mid-slot at counter 5, index 2
        for (int k = 0; k < 4 * RD && !(m_cnt == 5 && m_idx == 2); k++) step(1'b0, 1'b0, rst_v);
        checks++;
        if (!(m_cnt == 5 && m_idx == 2)) begin
            errors++;
            $display("FAIL mid_slot_reach: got cnt=%0d idx=%0d, required cnt=5 idx=2", m_cnt, m_idx);
        end
        step(1'b1, 1'b0, rst_v);
        repeat (4 * RD + 4) step(1'b0, 1'b0, rst_v);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d entries left, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
